shader_upload_ctrl: RTL and testbench



---
 rtl/shader_upload_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_shader_upload_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_upload_ctrl.sv
// ---------------------------------------------------------------------------
// shader_upload_ctrl
//
// SPI upload controller and frame-boundary scheduler for the tiny shader core.
// SPI bytes are deserialised in the clk_i domain. Program bytes from a WRITE
// transaction go into a small FIFO, each tagged with its program address.
// The FIFO drains into the shader's shadow program memory, and a single
// commit pulse is issued at a frame start so a new program never goes live
// half-written.
//
// Optional feature: define TINY_SHADER_READBACK_EN to enable command 0x02
// (status readback over MISO). Without it, 0x02 is an unknown command and
// spi_miso_o is tied low.
//
// Ports:
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   spi_sclk_i         SPI clock (mode 0), asynchronous, at most clk_i/4
//   spi_mosi_i         SPI data in, MSB first, sampled on SCLK rise
//   spi_cs_i           SPI chip select, active low
//   spi_miso_o         SPI data out, updated on SCLK fall
//   next_frame_i       one-cycle pulse at frame start
//   mem_addr_o         shadow memory write address (FIFO head)
//   mem_data_o         shadow memory write data (FIFO head)
//   mem_we_o           write request, held until accepted (FIFO non-empty)
//   mem_ready_i        write accepted when high together with mem_we_o
//   commit_o           one-cycle pulse: shadow memory becomes live
//   overflow_o         sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module shader_upload_ctrl #(
    parameter int NUM_INSTR  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         spi_sclk_i,
    input  logic                         spi_mosi_i,
    input  logic                         spi_cs_i,
    output logic                         spi_miso_o,
    input  logic                         next_frame_i,
    output logic [$clog2(NUM_INSTR)-1:0] mem_addr_o,
    output logic [7:0]                   mem_data_o,
    output logic                         mem_we_o,
    input  logic                         mem_ready_i,
    output logic                         commit_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(NUM_INSTR);
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_STATUS,
        ST_SKIP
    } state_t;

    // ---------------- synchronisers ----------------
    // sclk_sync_reg[2] is the extra stage used only for edge detection.
    logic [2:0] sclk_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic [1:0] cs_sync_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_sync_reg   <= 2'b11;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi_sclk_i};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi_i};
            cs_sync_reg   <= {cs_sync_reg[0], spi_cs_i};
        end
    end

    logic sclk_rise;
    logic cs_high;
    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign cs_high   = cs_sync_reg[1];

    // ---------------- byte deserialiser ----------------
    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_shift_reg;
    logic       byte_valid_reg;   // rx_shift_reg holds a complete byte this cycle

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_reg    <= '0;
            rx_shift_reg   <= '0;
            byte_valid_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (cs_high) begin
                bit_cnt_reg <= '0;    // discards any partial byte
            end else if (sclk_rise) begin
                rx_shift_reg <= {rx_shift_reg[6:0], mosi_sync_reg[1]};
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_valid_reg <= 1'b1;
                end
            end
        end
    end

    // ---------------- command FSM ----------------
    state_t state_reg, state_next;
    logic   write_start;
    logic   push_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        write_start = 1'b0;
        push_req    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!cs_high) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (cs_high) begin
                    state_next = ST_IDLE;
                end else if (byte_valid_reg) begin
                    if (rx_shift_reg == 8'h00) begin
                        state_next  = ST_WRITE;
                        write_start = 1'b1;
`ifdef TINY_SHADER_READBACK_EN
                    end else if (rx_shift_reg == 8'h02) begin
                        state_next = ST_STATUS;
`endif
                    end else begin
                        state_next = ST_SKIP;
                    end
                end
            end
            ST_WRITE: begin
                // A byte completing just as CS rises is still taken.
                push_req = byte_valid_reg;
                if (cs_high) state_next = ST_IDLE;
            end
            ST_STATUS, ST_SKIP: begin
                if (cs_high) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- upload FIFO ----------------
    logic [AW-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [7:0]    fifo_data_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FW:0]   count_reg;
    logic [AW-1:0] prog_addr_reg;
    logic          fifo_empty, fifo_full, push, drop, pop;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (FW+1)'(FIFO_DEPTH));
    assign push       = push_req & ~fifo_full;
    assign drop       = push_req & fifo_full;
    assign pop        = mem_we_o & mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= prog_addr_reg;
            fifo_data_mem[wr_ptr_reg] <= rx_shift_reg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            prog_addr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Program address wraps, so byte NUM_INSTR+k lands on address k.
            if (write_start)  prog_addr_reg <= '0;
            else if (push)    prog_addr_reg <= prog_addr_reg + 1'b1;
        end
    end

    // Head entry is shown only while valid, so the outputs idle at zero.
    assign mem_we_o   = ~fifo_empty;
    assign mem_addr_o = fifo_empty ? '0    : fifo_addr_mem[rd_ptr_reg];
    assign mem_data_o = fifo_empty ? 8'h00 : fifo_data_mem[rd_ptr_reg];

    // ---------------- overflow and commit scheduling ----------------
    logic overflow_reg, wrote_any_reg, commit_pending_reg, commit_reg;
    logic commit_fire;

    // CS must be high: a WRITE in progress may still be filling the FIFO.
    assign commit_fire = next_frame_i & commit_pending_reg & fifo_empty & cs_high;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_reg       <= 1'b0;
            wrote_any_reg      <= 1'b0;
            commit_pending_reg <= 1'b0;
            commit_reg         <= 1'b0;
        end else begin
            if (write_start)  overflow_reg <= 1'b0;
            else if (drop)    overflow_reg <= 1'b1;

            if (write_start)  wrote_any_reg <= 1'b0;
            else if (push)    wrote_any_reg <= 1'b1;

            // WRITE with CS high is the single cycle at the end of the transaction.
            if (state_reg == ST_WRITE && cs_high && (wrote_any_reg || push))
                commit_pending_reg <= 1'b1;
            else if (commit_fire)
                commit_pending_reg <= 1'b0;

            commit_reg <= commit_fire;
        end
    end

    assign commit_o   = commit_reg;
    assign overflow_o = overflow_reg;

    // ---------------- status readback ----------------
`ifdef TINY_SHADER_READBACK_EN
    logic       sclk_fall;
    logic [7:0] status_byte;
    logic [7:0] tx_shift_reg;
    logic       miso_reg;

    assign sclk_fall   = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign status_byte = {overflow_reg, commit_pending_reg, fifo_empty, fifo_full, 4'b0101};

    // bit_cnt_reg is zero at the fall that ends a byte, so that fall reloads
    // the status and presents its MSB before the next byte's first rise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift_reg <= '0;
            miso_reg     <= 1'b0;
        end else if (cs_high) begin
            miso_reg <= 1'b0;
        end else if (sclk_fall) begin
            if (bit_cnt_reg == 3'd0) begin
                miso_reg     <= status_byte[7];
                tx_shift_reg <= {status_byte[6:0], 1'b0};
            end else begin
                miso_reg     <= tx_shift_reg[7];
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
        end
    end

    assign spi_miso_o = miso_reg;
`else
    assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_shader_upload_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shader_upload_ctrl
//
// Directed testbench for shader_upload_ctrl (NUM_INSTR=8, FIFO_DEPTH=4).
// Inputs change 2 ns after a rising clk edge; memory writes and commits are
// logged on the falling edge. SCLK runs at clk/8.
// ---------------------------------------------------------------------------
module tb_shader_upload_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       miso;
    logic       nf = 1'b0;
    logic [2:0] addr;
    logic [7:0] data;
    logic       we;
    logic       ready = 1'b0;
    logic       commit;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    logic [2:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         commit_cnt = 0;

    shader_upload_ctrl #(.NUM_INSTR(8), .FIFO_DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sclk_i   (sclk),
        .spi_mosi_i   (mosi),
        .spi_cs_i     (cs),
        .spi_miso_o   (miso),
        .next_frame_i (nf),
        .mem_addr_o   (addr),
        .mem_data_o   (data),
        .mem_we_o     (we),
        .mem_ready_i  (ready),
        .commit_o     (commit),
        .overflow_o   (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (we && ready) begin
                wr_addr_q.push_back(addr);
                wr_data_q.push_back(data);
            end
            if (commit) commit_cnt++;
        end
    end

    task automatic sync_in();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        commit_cnt = 0;
    endtask

    task automatic cs_low();
        sync_in();
        cs = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_high();
        wait_cyc(2);
        cs = 1'b1;
        wait_cyc(6);
    endtask

    // Full byte; MISO is sampled just before each rise.
    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        sync_in();
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            rx[i] = miso;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        $display("spi byte tx=%02h rx=%02h", tx, rx);
    endtask

    task automatic spi_send(input logic [7:0] tx);
        logic [7:0] rx;
        spi_xfer(tx, rx);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        sync_in();
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #40;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        $display("spi partial tx=%02h bits=%0d", tx, n);
    endtask

    // Returns in the cycle after the pulse, when a commit would be visible.
    task automatic pulse_frame();
        sync_in();
        nf = 1'b1;
        sync_in();
        nf = 1'b0;
        $display("frame pulse commit_o=%0b", commit);
    endtask

    task automatic test_reset();
        wait_cyc(3);
        checks++; if (we !== 1'b0)     begin failures++; $display("FAIL rst_we got=%0b exp=0", we); end
        checks++; if (addr !== 3'd0)   begin failures++; $display("FAIL rst_addr got=%0d exp=0", addr); end
        checks++; if (data !== 8'h00)  begin failures++; $display("FAIL rst_data got=%02h exp=00", data); end
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%0b exp=0", commit); end
        checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
        checks++; if (miso !== 1'b0)   begin failures++; $display("FAIL rst_miso got=%0b exp=0", miso); end
        sync_in();
        rst = 1'b0;
        wait_cyc(4);
        checks++; if (we !== 1'b0)     begin failures++; $display("FAIL post_rst_we got=%0b exp=0", we); end
    endtask

    task automatic test_program_load();
        clear_log();
        sync_in();
        ready = 1'b1;
        cs_low();
        spi_send(8'h00);
        for (int i = 0; i < 8; i++) spi_send(8'h11 + 8'(i));
        cs_high();
        wait_cyc(10);
        checks++;
        if (wr_addr_q.size() !== 8) begin failures++; $display("FAIL load_count got=%0d exp=8", wr_addr_q.size()); end
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 3'(i) || wr_data_q[i] !== 8'h11 + 8'(i)) begin
                failures++;
                $display("FAIL load_entry%0d got=%0d/%02h exp=%0d/%02h", i, wr_addr_q[i], wr_data_q[i], i, 8'h11 + 8'(i));
            end
        end
        checks++; if (commit_cnt !== 0) begin failures++; $display("FAIL load_early_commit got=%0d exp=0", commit_cnt); end
        pulse_frame();
        checks++; if (commit !== 1'b1) begin failures++; $display("FAIL load_commit got=%0b exp=1", commit); end
        wait_cyc(1);
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL load_commit_width got=%0b exp=0", commit); end
        wait_cyc(3);
        checks++; if (commit_cnt !== 1) begin failures++; $display("FAIL load_commit_cnt got=%0d exp=1", commit_cnt); end
    endtask

    task automatic test_overflow_deferred();
        clear_log();
        sync_in();
        ready = 1'b0;
        cs_low();
        spi_send(8'h00);
        for (int i = 0; i < 6; i++) spi_send(8'h21 + 8'(i));
        cs_high();
        wait_cyc(4);
        checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
        checks++; if (we !== 1'b1)    begin failures++; $display("FAIL ovf_we_held got=%0b exp=1", we); end
        checks++; if (addr !== 3'd0 || data !== 8'h21) begin failures++; $display("FAIL ovf_head got=%0d/%02h exp=0/21", addr, data); end
        pulse_frame();
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL deferred_no_commit got=%0b exp=0", commit); end
        sync_in();
        ready = 1'b1;
        wait_cyc(10);
        checks++;
        if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 3'(i) || wr_data_q[i] !== 8'h21 + 8'(i)) begin
                failures++;
                $display("FAIL ovf_entry%0d got=%0d/%02h exp=%0d/%02h", i, wr_addr_q[i], wr_data_q[i], i, 8'h21 + 8'(i));
            end
        end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", we); end
        pulse_frame();
        checks++; if (commit !== 1'b1) begin failures++; $display("FAIL deferred_commit got=%0b exp=1", commit); end
        checks++; if (ovf !== 1'b1)    begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
        cs_low();
        spi_send(8'h00);
        cs_high();
        checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
    endtask

    task automatic test_wrap_abort();
        clear_log();
        sync_in();
        ready = 1'b1;
        cs_low();
        spi_send(8'h00);
        for (int i = 0; i < 10; i++) spi_send(8'h31 + 8'(i));
        spi_bits(8'hF0, 4);
        cs_high();
        wait_cyc(10);
        checks++;
        if (wr_addr_q.size() !== 10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", wr_addr_q.size()); end
        for (int i = 0; i < 10 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== 3'(i % 8) || wr_data_q[i] !== 8'h31 + 8'(i)) begin
                failures++;
                $display("FAIL wrap_entry%0d got=%0d/%02h exp=%0d/%02h", i, wr_addr_q[i], wr_data_q[i], i % 8, 8'h31 + 8'(i));
            end
        end
        pulse_frame();
        checks++; if (commit !== 1'b1) begin failures++; $display("FAIL wrap_commit got=%0b exp=1", commit); end
    endtask

    task automatic test_skip();
        logic [7:0] rx;
        clear_log();
        cs_low();
        spi_send(8'h7F);
        spi_send(8'h55);
        spi_send(8'hAA);
        cs_high();
        cs_low();
        spi_send(8'h02);
        spi_xfer(8'h66, rx);
        cs_high();
        wait_cyc(4);
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL skip_writes got=%0d exp=0", wr_addr_q.size()); end
`ifndef TINY_SHADER_READBACK_EN
        checks++; if (rx !== 8'h00) begin failures++; $display("FAIL miso_tied got=%02h exp=00", rx); end
`endif
        pulse_frame();
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL skip_no_commit got=%0b exp=0", commit); end
    endtask

`ifdef TINY_SHADER_READBACK_EN
    task automatic test_status();
        logic [7:0] rx0, rx1, rx2;
        clear_log();
        sync_in();
        ready = 1'b0;
        cs_low();
        spi_send(8'h00);
        for (int i = 0; i < 5; i++) spi_send(8'h41 + 8'(i));
        cs_high();
        sync_in();
        ready = 1'b1;
        wait_cyc(10);
        checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL status_drain got=%0d exp=4", wr_addr_q.size()); end
        // overflow=1, commit_pending=1, fifo_empty=1, fifo_full=0, 0101
        cs_low();
        spi_xfer(8'h02, rx0);
        spi_xfer(8'h00, rx1);
        spi_xfer(8'h00, rx2);
        cs_high();
        checks++; if (rx1 !== 8'hE5) begin failures++; $display("FAIL status_byte1 got=%02h exp=e5", rx1); end
        checks++; if (rx2 !== 8'hE5) begin failures++; $display("FAIL status_byte2 got=%02h exp=e5", rx2); end
        pulse_frame();
        checks++; if (commit !== 1'b1) begin failures++; $display("FAIL status_commit got=%0b exp=1", commit); end
    endtask
`endif

    task automatic test_reset_mid();
        clear_log();
        sync_in();
        ready = 1'b0;
        cs_low();
        spi_send(8'h00);
        spi_send(8'h51);
        spi_send(8'h52);
        spi_bits(8'hA0, 4);
        wait_cyc(4);
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL rmid_pre_we got=%0b exp=1", we); end
        sync_in();
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        checks++; if (we !== 1'b0)  begin failures++; $display("FAIL rmid_we got=%0b exp=0", we); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%0b exp=0", ovf); end
        cs_high();
        sync_in();
        ready = 1'b1;
        wait_cyc(10);
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL rmid_writes got=%0d exp=0", wr_addr_q.size()); end
        pulse_frame();
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL rmid_commit got=%0b exp=0", commit); end
        wait_cyc(3);
        checks++; if (commit_cnt !== 0) begin failures++; $display("FAIL rmid_commit_cnt got=%0d exp=0", commit_cnt); end
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_overflow_deferred();
        test_wrap_abort();
        test_skip();
`ifdef TINY_SHADER_READBACK_EN
        test_status();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
